// File: rtl/pipe_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared stall/flush encodings and FSM states       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic        STOP      = 1'b1;
  localparam logic        NOSTOP    = 1'b0;

  localparam logic [5:0]  STALL_EX  = 6'b001111;
  localparam logic [5:0]  STALL_ID  = 6'b000111;
  localparam logic [5:0]  STALL_IF  = 6'b000011;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;

  localparam logic [1:0]  CTRL_RUN   = 2'd0;
  localparam logic [1:0]  CTRL_STALL = 2'd1;
  localparam logic [1:0]  CTRL_FLUSH = 2'd2;
  localparam logic [1:0]  CTRL_MASK  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = CTRL_RUN,
    ST_STALL = CTRL_STALL,
    ST_FLUSH = CTRL_FLUSH,
    ST_MASK  = CTRL_MASK
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
// +------------------------------------------------------------------+
// | sat_counter : up-counter with enable, sync clear, saturates at max|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear has priority over increment; the all-ones value is sticky.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// +------------------------------------------------------------------+
// | pipe_ctrl : stall/flush control, stall perf counter, and optional |
// | stall watchdog enabled by CTRL_WDOG_EN.            Rev 1.0        |
// +------------------------------------------------------------------+
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;
  logic [5:0]  req_stall;
  logic        squashed;
  logic        stall_any;

  if ((WDOG_CYCLES < 2) || (WDOG_CYCLES > 65535)) begin : g_wdog_range_err
    $error("pipe_ctrl: WDOG_CYCLES must be within 2..65535");
  end

  // A state of FLUSH means the previous cycle flushed: ID/EX requests now
  // come from squashed instructions.
  assign squashed = (state_q == ST_FLUSH);

  always_comb begin
    req_stall = {6{NOSTOP}};
    if (stallreq_ex && !squashed) begin
      req_stall = STALL_EX;
    end else if (stallreq_id && !squashed) begin
      req_stall = STALL_ID;
    end else if (stallreq_if) begin
      req_stall = STALL_IF;
    end
  end

  always_comb begin
    stall  = {6{NOSTOP}};
    flush  = 1'b0;
    new_pc = ZeroWord;
    if (rst != RstEnable) begin
      if (flush_req) begin
        flush  = 1'b1;
        new_pc = flush_pc;
      end else begin
        stall  = req_stall;
      end
    end
  end

  // Every stall encoding holds the PC.
  assign stall_any = (stall[0] == STOP);

  always_comb begin
    state_d = ST_RUN;
    if (flush_req) begin
      state_d = ST_FLUSH;
    end else if (state_q == ST_FLUSH) begin
      state_d = ST_MASK;
    end else if (stall_any) begin
      state_d = ST_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (stall_any),
    .cnt (stall_cycles)
  );

`ifdef CTRL_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

  logic [15:0] wdog_cnt;
  logic        timeout_q;
  logic        timeout_d;

  sat_counter #(
    .WIDTH (16)
  ) u_wdog_cnt (
    .clk (clk),
    .rst (rst),
    .clr (flush | ~stall_any),
    .en  (stall_any),
    .cnt (wdog_cnt)
  );

  // Trip on the edge where the run counter reaches WDOG_CYCLES.
  always_comb begin
    timeout_d = timeout_q;
    if (stall_any && (wdog_cnt >= WDOG_LAST)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout = timeout_q;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// +------------------------------------------------------------------+
// | tb_pipe_ctrl : directed self-checking bench for pipe_ctrl         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;

  int total = 0;
  int bad   = 0;

`ifdef CTRL_WDOG_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  pipe_ctrl #(
    .WDOG_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .flush_req     (flush_req),
    .flush_pc      (flush_pc),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_cycles  (stall_cycles),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic i_f, input logic i_d, input logic i_e);
    stallreq_if = i_f;
    stallreq_id = i_d;
    stallreq_ex = i_e;
  endtask

  initial begin
    rst = 1'b1; req(1, 1, 1); flush_req = 1'b1; flush_pc = 32'hDEAD_BEEF;
    cyc(); cyc();
    #1;
    chk("rst_stall", {26'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_new_pc", new_pc, 32'd0);
    chk("rst_cycles", stall_cycles, 32'd0);
    chk("rst_timeout", {31'd0, stall_timeout}, 32'd0);

    rst = 1'b0; flush_req = 1'b0; req(0, 1, 0); #1;
    chk("post_rst_id", {26'd0, stall}, 32'b000111);
    cyc();

    req(1, 1, 1); #1;
    chk("pri_ex", {26'd0, stall}, 32'b001111);
    cyc();
    req(1, 1, 0); #1;
    chk("pri_id", {26'd0, stall}, 32'b000111);
    cyc();
    req(1, 0, 0); #1;
    chk("pri_if", {26'd0, stall}, 32'b000011);
    cyc();
    chk("cycles_4", stall_cycles, 32'd4);
    req(0, 0, 0); #1;
    chk("idle_stall", {26'd0, stall}, 32'd0);
    cyc();

    req(0, 0, 1); flush_req = 1'b1; flush_pc = 32'h0000_0100; #1;
    chk("fl_flush", {31'd0, flush}, 32'd1);
    chk("fl_new_pc", new_pc, 32'h100);
    chk("fl_stall", {26'd0, stall}, 32'd0);
    cyc();
    flush_req = 1'b0; #1;
    chk("mask_ex", {26'd0, stall}, 32'd0);
    chk("mask_flush", {31'd0, flush}, 32'd0);
    chk("mask_new_pc", new_pc, 32'd0);
    cyc();
    #1;
    chk("after_mask_ex", {26'd0, stall}, 32'b001111);
    cyc();
    chk("cycles_5", stall_cycles, 32'd5);

    req(0, 0, 0); flush_req = 1'b1; flush_pc = 32'h0000_0200; #1;
    chk("b2b_pc1", new_pc, 32'h200);
    cyc();
    req(0, 1, 0); flush_pc = 32'h0000_0300; #1;
    chk("b2b_pc2", new_pc, 32'h300);
    chk("b2b_stall", {26'd0, stall}, 32'd0);
    cyc();
    flush_req = 1'b0; req(1, 1, 1); #1;
    chk("mask_if", {26'd0, stall}, 32'b000011);
    cyc();
    req(0, 0, 0); cyc();
    chk("cycles_6", stall_cycles, 32'd6);

    req(0, 0, 1); cyc();
    rst = 1'b1; #1;
    chk("rst_force_stall", {26'd0, stall}, 32'd0);
    cyc();
    rst = 1'b0; #1;
    chk("rst_mid_cycles", stall_cycles, 32'd0);
    chk("rst_mid_stall", {26'd0, stall}, 32'b001111);
    cyc();
    req(0, 0, 0); flush_req = 1'b1; cyc();
    rst = 1'b1; flush_req = 1'b0; req(0, 1, 0); cyc();
    rst = 1'b0; #1;
    chk("no_residual_mask", {26'd0, stall}, 32'b000111);
    cyc();
    chk("cycles_after_rst", stall_cycles, 32'd1);
    req(0, 0, 0);

    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 7; i++) begin req(0, 0, 1); cyc(); end
    req(0, 0, 0); cyc();
    for (int i = 0; i < 7; i++) begin req(1, 0, 0); cyc(); end
    chk("wd_7_1_7", {31'd0, stall_timeout}, 32'd0);
    req(0, 0, 0); cyc();
    for (int i = 0; i < 7; i++) begin req(0, 1, 0); cyc(); end
    chk("wd_7", {31'd0, stall_timeout}, 32'd0);
    req(0, 1, 0); cyc();
    chk("wd_8", {31'd0, stall_timeout}, {31'd0, TO_EXP});
    req(0, 0, 0); cyc(); cyc();
    chk("wd_sticky", {31'd0, stall_timeout}, {31'd0, TO_EXP});
    chk("stall_unaltered", {26'd0, stall}, 32'd0);
    rst = 1'b1; cyc(); rst = 1'b0; #1;
    chk("wd_rst", {31'd0, stall_timeout}, 32'd0);

    dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    req(0, 0, 1); cyc();
    chk("sat_reach", stall_cycles, 32'hFFFF_FFFF);
    cyc(); cyc(); cyc();
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    req(0, 0, 0); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule

`default_nettype wire
